// File: rtl/vga_pkg.sv
// vga_pkg: shared XGA (1024x768 @ 60 Hz, 65 MHz pixel clock) timing constants,
// colour constants and the vga_bus record passed between draw stages.
//
// Contents:
//   CNT_W                      counter width (11 bits)
//   H_* / V_*                  raster geometry in pixels / lines
//   H_LAST, V_LAST, *_FIRST    counter-width decode points derived from the geometry
//   RGB_*                      12-bit colour constants (4 bits per channel)
//   vga_bus_t                  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
package vga_pkg;

  localparam int unsigned CNT_W = 11;

  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned H_FP     = 24;
  localparam int unsigned H_SYNC   = 136;
  localparam int unsigned H_TOTAL  = 1344;

  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned V_FP     = 3;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_TOTAL  = 806;

  // Decode points at counter width; blanking ends at the wrap, so only its start is needed.
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HBLNK_FIRST = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HSYNC_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSYNC_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VBLNK_FIRST = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VSYNC_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [11:0] RGB_WHITE   = 12'hFFF;
  localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
  localparam logic [11:0] RGB_CYAN    = 12'h0FF;
  localparam logic [11:0] RGB_GREEN   = 12'h0F0;
  localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
  localparam logic [11:0] RGB_RED     = 12'hF00;
  localparam logic [11:0] RGB_BLUE    = 12'h00F;
  localparam logic [11:0] RGB_BLACK   = 12'h000;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
    logic [11:0]      rgb;
  } vga_bus_t;

endpackage

// File: rtl/vga_test_pattern.sv
// vga_test_pattern: combinational colour-bar generator. Eight vertical bars,
// 128 pixels wide, left to right: white, yellow, cyan, green, magenta, red,
// blue, black. Output is black whenever either blanking flag is set.
//
// Ports:
//   bar_sel_i [2:0]  hcount[9:7] of the pixel being coloured
//   hblnk_i          horizontal blanking flag of that pixel
//   vblnk_i          vertical blanking flag of that pixel
//   rgb_o [11:0]     bar colour
module vga_test_pattern
  import vga_pkg::*;
(
  input  logic [2:0]  bar_sel_i,
  input  logic        hblnk_i,
  input  logic        vblnk_i,
  output logic [11:0] rgb_o
);

  always_comb begin
    rgb_o = RGB_BLACK;
    if (!(hblnk_i || vblnk_i)) begin
      case (bar_sel_i)
        3'd0:    rgb_o = RGB_WHITE;
        3'd1:    rgb_o = RGB_YELLOW;
        3'd2:    rgb_o = RGB_CYAN;
        3'd3:    rgb_o = RGB_GREEN;
        3'd4:    rgb_o = RGB_MAGENTA;
        3'd5:    rgb_o = RGB_RED;
        3'd6:    rgb_o = RGB_BLUE;
        default: rgb_o = RGB_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: head of the vga_bus pipeline. Generates the XGA raster
// counters, active-high sync/blanking flags and a one-cycle frame-start strobe.
// Every bus field is decoded from the next count and registered alongside it,
// so all fields in a cycle describe the same pixel.
//
// Ports:
//   clk          65 MHz pixel clock
//   rst_n        asynchronous active-low reset (clears all outputs)
//   en           count enable; low freezes the raster and all bus fields
//   bus_out      vga_bus_t: hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
//   frame_start  one-cycle pulse in the cycle bus_out first shows (0,0) after a wrap
//
// Build option: define VGA_TIMING_TEST_PATTERN_EN to drive colour bars on rgb;
// otherwise rgb is constant 0.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  output vga_bus_t bus_out,
  output logic     frame_start
);

  vga_bus_t         bus_q, bus_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_last, v_last;
  logic             hblnk_nxt, vblnk_nxt;
  logic [11:0]      rgb_nxt;

  always_comb begin
    h_last = (bus_q.hcount == H_LAST);
    v_last = (bus_q.vcount == V_LAST);

    h_nxt = bus_q.hcount;
    v_nxt = bus_q.vcount;
    if (en) begin
      if (h_last) begin
        h_nxt = '0;
        v_nxt = v_last ? '0 : bus_q.vcount + 1'b1;
      end else begin
        h_nxt = bus_q.hcount + 1'b1;
      end
    end

    hblnk_nxt = (h_nxt >= HBLNK_FIRST);
    vblnk_nxt = (v_nxt >= VBLNK_FIRST);
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  vga_test_pattern u_test_pattern (
    .bar_sel_i (h_nxt[9:7]),
    .hblnk_i   (hblnk_nxt),
    .vblnk_i   (vblnk_nxt),
    .rgb_o     (rgb_nxt)
  );
`else
  always_comb begin
    rgb_nxt = RGB_BLACK;
  end
`endif

  // With en low the next count equals the current one, so re-decoding it
  // reproduces the held flags and colour without a separate hold path.
  always_comb begin
    bus_d        = '0;
    bus_d.hcount = h_nxt;
    bus_d.vcount = v_nxt;
    bus_d.hblnk  = hblnk_nxt;
    bus_d.vblnk  = vblnk_nxt;
    bus_d.hsync  = (h_nxt >= HSYNC_FIRST) && (h_nxt <= HSYNC_LAST);
    bus_d.vsync  = (v_nxt >= VSYNC_FIRST) && (v_nxt <= VSYNC_LAST);
    bus_d.rgb    = rgb_nxt;

    // Pulse only on an actual frame wrap, so (0,0) after reset or a frozen
    // (0,0) never raises it.
    frame_start_d = en && h_last && v_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      bus_q         <= bus_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus_out     = bus_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     en;
  vga_bus_t bus_out;
  logic     frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference raster position and enabled-cycle count since last reset release.
  int mh   = 0;
  int mv   = 0;
  int ncyc = 0;

  logic [11:0] rgb_130_100;
  logic [11:0] rgb_900_100;
  logic [11:0] rgb_130_780;
  int          rgb_err = 0;

  vga_timing_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .bus_out     (bus_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // One clock; the reference position advances on enabled edges. Returns at the
  // following falling edge, where outputs are sampled and inputs changed.
  task automatic tick();
    @(posedge clk);
    if (en && rst_n) begin
      ncyc++;
      if (mh == 1343) begin
        mh = 0;
        mv = (mv == 805) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int h, input int v, input int limit);
    int guard = 0;
    while (!(mh == h && mv == v) && guard < limit) begin
      tick();
      guard++;
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v);
    logic [11:0] c = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    if (h < 1024 && v < 768) begin
      case (h / 128)
        0: c = 12'hFFF;
        1: c = 12'hFF0;
        2: c = 12'h0FF;
        3: c = 12'h0F0;
        4: c = 12'hF0F;
        5: c = 12'hF00;
        6: c = 12'h00F;
        default: c = 12'h000;
      endcase
    end
`endif
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus_out !== '0) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0", bus_out);
    end
    n_checks++;
    if (frame_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_start: got %b expected 0", frame_start);
    end
    rst_n = 1'b1;
    mh = 0; mv = 0; ncyc = 0;
    tick();
    n_checks++;
    if (bus_out.hcount !== 11'd1) begin
      n_fail++; $display("FAIL first_hcount: got %0d expected 1", bus_out.hcount);
    end
    n_checks++;
    if (bus_out.vcount !== 11'd0) begin
      n_fail++; $display("FAIL first_vcount: got %0d expected 0", bus_out.vcount);
    end
    n_checks++;
    if (frame_start !== 1'b0) begin
      n_fail++; $display("FAIL first_frame_start: got %b expected 0", frame_start);
    end
  endtask

  task automatic test_line_boundary();
    int trk = 0, hb_first = -1, hb_bad = 0, hs_n = 0, hs_first = -1, hs_last = -1;
    int vflag = 0, guard = 0;
    do begin
      tick();
      guard++;
      if (int'(bus_out.hcount) != mh || int'(bus_out.vcount) != mv) trk++;
      if (bus_out.hblnk === 1'b1 && hb_first < 0) hb_first = mh;
      if (bus_out.hblnk !== (mh >= 1024)) hb_bad++;
      if (bus_out.hsync === 1'b1) begin
        hs_n++;
        if (hs_first < 0) hs_first = mh;
        hs_last = mh;
      end
      if (bus_out.vsync !== 1'b0 || bus_out.vblnk !== 1'b0 || frame_start !== 1'b0) vflag++;
    end while (!(mh == 0 && mv == 1) && guard < 2000);

    n_checks++;
    if (trk != 0) begin n_fail++; $display("FAIL line_track: %0d cycles off, expected 0", trk); end
    n_checks++;
    if (hb_first != 1024) begin n_fail++; $display("FAIL hblnk_rise: got %0d expected 1024", hb_first); end
    n_checks++;
    if (hb_bad != 0) begin n_fail++; $display("FAIL hblnk_span: %0d bad cycles, expected 0", hb_bad); end
    n_checks++;
    if (hs_n != 136) begin n_fail++; $display("FAIL hsync_len: got %0d expected 136", hs_n); end
    n_checks++;
    if (hs_first != 1048) begin n_fail++; $display("FAIL hsync_first: got %0d expected 1048", hs_first); end
    n_checks++;
    if (hs_last != 1183) begin n_fail++; $display("FAIL hsync_last: got %0d expected 1183", hs_last); end
    n_checks++;
    if (vflag != 0) begin n_fail++; $display("FAIL line0_vflags: %0d bad cycles, expected 0", vflag); end
    n_checks++;
    if (bus_out.hcount !== 11'd0) begin n_fail++; $display("FAIL line_wrap_h: got %0d expected 0", bus_out.hcount); end
    n_checks++;
    if (bus_out.vcount !== 11'd1) begin n_fail++; $display("FAIL line_wrap_v: got %0d expected 1", bus_out.vcount); end
  endtask

  task automatic test_enable_freeze();
    vga_bus_t exp;
    int hold_err = 0, fs_hi = 0;
    exp        = '0;
    exp.hcount = 11'd500;
    exp.vcount = 11'd10;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    exp.rgb    = 12'h0F0;
`endif
    run_to(500, 10, 20000);
    n_checks++;
    if (bus_out !== exp) begin n_fail++; $display("FAIL freeze_reach: got %h expected %h", bus_out, exp); end
    en = 1'b0;
    repeat (20) begin
      tick();
      if (bus_out !== exp) hold_err++;
      if (frame_start !== 1'b0) fs_hi++;
    end
    n_checks++;
    if (hold_err != 0) begin n_fail++; $display("FAIL freeze_hold: %0d cycles moved, expected 0", hold_err); end
    n_checks++;
    if (fs_hi != 0) begin n_fail++; $display("FAIL freeze_frame_start: %0d high cycles, expected 0", fs_hi); end
    en = 1'b1;
    tick();
    n_checks++;
    if (bus_out.hcount !== 11'd501) begin n_fail++; $display("FAIL resume_h: got %0d expected 501", bus_out.hcount); end
    n_checks++;
    if (bus_out.vcount !== 11'd10) begin n_fail++; $display("FAIL resume_v: got %0d expected 10", bus_out.vcount); end
  endtask

  task automatic test_frame_wrap();
    int vs_n = 0, vs_first = -1, vs_last = -1, vb_n = 0, vb_first = -1, vb_last = -1;
    int incons = 0, fs_early = 0, trk = 0, guard = 0;
    logic vs_line, vb_line;
    vs_line = bus_out.vsync;
    vb_line = bus_out.vblnk;
    while (!(mh == 1343 && mv == 805) && guard < 1100000) begin
      tick();
      guard++;
      if (int'(bus_out.hcount) != mh || int'(bus_out.vcount) != mv) trk++;
      if (mh == 0) begin
        vs_line = bus_out.vsync;
        vb_line = bus_out.vblnk;
        if (vs_line === 1'b1) begin
          vs_n++;
          if (vs_first < 0) vs_first = mv;
          vs_last = mv;
        end
        if (vb_line === 1'b1) begin
          vb_n++;
          if (vb_first < 0) vb_first = mv;
          vb_last = mv;
        end
      end else if (bus_out.vsync !== vs_line || bus_out.vblnk !== vb_line) begin
        incons++;
      end
      if (frame_start !== 1'b0) fs_early++;
      if (bus_out.rgb !== exp_rgb(mh, mv)) rgb_err++;
      if (mh == 130 && mv == 100) rgb_130_100 = bus_out.rgb;
      if (mh == 900 && mv == 100) rgb_900_100 = bus_out.rgb;
      if (mh == 130 && mv == 780) rgb_130_780 = bus_out.rgb;
    end

    n_checks++;
    if (bus_out.hcount !== 11'd1343 || bus_out.vcount !== 11'd805) begin
      n_fail++; $display("FAIL frame_reach: got (%0d,%0d) expected (1343,805)", bus_out.hcount, bus_out.vcount);
    end
    n_checks++;
    if (trk != 0) begin n_fail++; $display("FAIL frame_track: %0d cycles off, expected 0", trk); end
    n_checks++;
    if (vs_n != 6) begin n_fail++; $display("FAIL vsync_lines: got %0d expected 6", vs_n); end
    n_checks++;
    if (vs_first != 771 || vs_last != 776) begin
      n_fail++; $display("FAIL vsync_span: got %0d..%0d expected 771..776", vs_first, vs_last);
    end
    n_checks++;
    if (vb_n != 38) begin n_fail++; $display("FAIL vblnk_lines: got %0d expected 38", vb_n); end
    n_checks++;
    if (vb_first != 768 || vb_last != 805) begin
      n_fail++; $display("FAIL vblnk_span: got %0d..%0d expected 768..805", vb_first, vb_last);
    end
    n_checks++;
    if (incons != 0) begin n_fail++; $display("FAIL vflag_midline: %0d changes, expected 0", incons); end
    n_checks++;
    if (fs_early != 0) begin n_fail++; $display("FAIL frame_start_early: %0d high cycles, expected 0", fs_early); end

    tick();
    n_checks++;
    if (bus_out.hcount !== 11'd0 || bus_out.vcount !== 11'd0) begin
      n_fail++; $display("FAIL frame_wrap_pos: got (%0d,%0d) expected (0,0)", bus_out.hcount, bus_out.vcount);
    end
    n_checks++;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL frame_start_pulse: got %b expected 1", frame_start); end
    n_checks++;
    if (ncyc != 1083264) begin n_fail++; $display("FAIL frame_start_latency: got %0d expected 1083264", ncyc); end
    n_checks++;
    if (bus_out.vsync !== 1'b0 || bus_out.vblnk !== 1'b0 || bus_out.hsync !== 1'b0 || bus_out.hblnk !== 1'b0) begin
      n_fail++; $display("FAIL wrap_flags: got %b%b%b%b expected 0000",
                         bus_out.hsync, bus_out.hblnk, bus_out.vsync, bus_out.vblnk);
    end
    tick();
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL frame_start_width: got %b expected 0", frame_start); end
    n_checks++;
    if (bus_out.hcount !== 11'd1) begin n_fail++; $display("FAIL post_wrap_h: got %0d expected 1", bus_out.hcount); end
  endtask

  task automatic test_async_reset();
    run_to(700, 400, 600000);
    n_checks++;
    if (bus_out.hcount !== 11'd700 || bus_out.vcount !== 11'd400) begin
      n_fail++; $display("FAIL areset_reach: got (%0d,%0d) expected (700,400)", bus_out.hcount, bus_out.vcount);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_out !== '0) begin n_fail++; $display("FAIL areset_bus: got %h expected 0", bus_out); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL areset_frame_start: got %b expected 0", frame_start); end
    #1 rst_n = 1'b1;
    mh = 0; mv = 0; ncyc = 0;
    tick();
    n_checks++;
    if (bus_out.hcount !== 11'd1 || bus_out.vcount !== 11'd0) begin
      n_fail++; $display("FAIL areset_restart: got (%0d,%0d) expected (1,0)", bus_out.hcount, bus_out.vcount);
    end
  endtask

  task automatic test_test_pattern();
    logic [11:0] e_130_100 = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    e_130_100 = 12'hFF0;
`endif
    n_checks++;
    if (rgb_130_100 !== e_130_100) begin
      n_fail++; $display("FAIL rgb_130_100: got %h expected %h", rgb_130_100, e_130_100);
    end
    n_checks++;
    if (rgb_900_100 !== 12'h000) begin n_fail++; $display("FAIL rgb_900_100: got %h expected 000", rgb_900_100); end
    n_checks++;
    if (rgb_130_780 !== 12'h000) begin n_fail++; $display("FAIL rgb_130_780: got %h expected 000", rgb_130_780); end
    n_checks++;
    if (rgb_err != 0) begin n_fail++; $display("FAIL rgb_frame: %0d wrong pixels, expected 0", rgb_err); end
  endtask

  initial begin
    test_reset();
    test_line_boundary();
    test_enable_freeze();
    test_frame_wrap();
    test_async_reset();
    test_test_pattern();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Source end of the `vga_bus` pipeline. It generates the 1024x768 @ 60 Hz (XGA, 65 MHz pixel clock) counters, sync and blanking that every downstream draw stage consumes and re-registers. It sits at the head of the chain, ahead of the background and game-board draw stages. It also provides a one-cycle frame-start strobe for frame-synchronous game logic.

## Interface
- No parameters; all timing constants come from `vga_pkg`.
- `clk`  in  1  pixel clock, 65 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  count enable; low freezes the raster
- `bus_out`  vga_bus  —  hcount[10:0], vcount[10:0], hsync, hblnk, vsync, vblnk, rgb[11:0]
- `frame_start`  out  1  high for one cycle when bus_out shows hcount=0, vcount=0

## Operation
- Internal counters: `h_cnt` runs 0..1343; `v_cnt` runs 0..805. Both are 11-bit and unsigned.
- Horizontal wrap: when `h_cnt`=1343 and `en`=1, `h_cnt` goes to 0 and `v_cnt` increments.
- Frame wrap: when `h_cnt`=1343 and `v_cnt`=805, both counters go to 0 on the same edge.
- `en`=0: counters and every bus_out field hold their values; `frame_start` is forced to 0.
- Decoded flags, active-high on the bus (pad polarity is inverted at the top level, not here):
  - hblnk = hcount in 1024..1343
  - hsync = hcount in 1048..1183 (front porch 24, sync 136, back porch 160)
  - vblnk = vcount in 768..805
  - vsync = vcount in 771..776 (front porch 3, sync 6, back porch 29)
- Flags are decoded from the next-count value and registered with it, so every bus_out field in a given cycle describes the same pixel.
- rgb is 12'h000 unless `VGA_TIMING_TEST_PATTERN_EN` is defined (see Configuration).
- `frame_start` asserts when the registered bus_out shows (0,0) with `en`=1. It does not re-assert while `en` holds at (0,0).
- Out-of-range counter values cannot occur; no recovery logic is required.

## Timing
- Reset (async assert, clk-synchronous release): hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0, rgb=0, frame_start=0.
- First rising edge after `rst_n` rises with `en`=1: bus_out moves to hcount=1.
- Pixel (0,0) is therefore presented during reset and the first cycle after it.
- The first `frame_start` comes at the start of the second frame, exactly 1344*806 = 1,083,264 enabled cycles after reset release.
- All outputs are registered; there is no combinational path from any input to any output.
- `rst_n` asserted mid-frame clears everything immediately, without waiting for a clock edge.
- Line period: 1344 cycles. Frame period: 1,083,264 enabled cycles.

## Configuration
- Macro: `VGA_TIMING_TEST_PATTERN_EN`.
- **Defined:** rgb shows eight vertical colour bars, 128 px wide, selected by hcount[9:7] in this order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - rgb is 000 whenever hblnk or vblnk is set.
  - rgb is registered in the same cycle as the counts.
- **Not defined:** rgb is constant 000 and the bar logic is absent.

## Structure
- `vga_pkg` holds:
  - localparams H_ACTIVE=1024, H_FP=24, H_SYNC=136, H_TOTAL=1344
  - localparams V_ACTIVE=768, V_FP=3, V_SYNC=6, V_TOTAL=806
  - the 12-bit colour constants
  - the counter width localparam (11)
- One sub-module, `vga_test_pattern`: combinational bar colour from hcount and the blank flags. It is instantiated only under the macro.
- Counters, flag decode and output registers stay in `vga_timing_gen`.

## Test plan
- **Reset values:** hold `rst_n`=0 for 5 cycles, then release with `en`=1.
  - All outputs are 0 during reset.
  - Cycle 1 after release: hcount=1, vcount=0.
- **Line boundary:** run 1344 cycles.
  - hblnk rises at hcount=1024.
  - hsync is high for hcount 1048..1183 (exactly 136 cycles).
  - After hcount=1343: hcount=0, vcount=1.
- **Frame wrap:** run to hcount=1343, vcount=805.
  - Next edge gives (0,0) with frame_start=1 for exactly one cycle.
  - vsync was high for exactly 6 lines (771..776); vblnk covered lines 768..805.
- **Enable freeze:** drop `en` at hcount=500, vcount=10 for 20 cycles.
  - bus_out holds (500,10) and frame_start=0.
  - On re-enable, hcount=501 on the next edge.
- **Async reset mid-frame:** pulse `rst_n` low between edges at (700,400).
  - Outputs are 0 before the next edge.
  - Counting restarts from (0,0).
- **Test pattern (macro defined):**
  - At (130,100): rgb=FF0.
  - At (900,100): rgb=000.
  - At (130,780): rgb=000 (blanked).
  - Without the macro: rgb=000 everywhere.
